// File: rtl/echo_sequencer.sv
// echo_sequencer
// Runs one ultrasonic ranging cycle at a time. It emits the trigger pulse,
// synchronizes the asynchronous echo, and gates the echo into a clean
// `enable` window for the downstream pulse-period counter. Both waits are
// bounded by timeouts. Measurements repeat every REPEAT_CYC cycles while
// `start` is held.
//
// Optional feature: define ECHO_GLITCH_FILTER_EN to add a 3-cycle stability
// filter after the synchronizer. This raises echo latency from 3 to 5
// cycles on both edges.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   start    in   level; measurements repeat while high
//   echo     in   asynchronous sensor echo
//   trig     out  sensor trigger pulse (TRIG_CYC cycles)
//   enable   out  measurement window to the period counter
//   busy     out  high whenever the FSM is not in IDLE
//   timeout  out  one-cycle pulse on a wait-for-echo or echo-width timeout
//   state_o  out  current FSM state (debug observation)
//
// Handshake: there is none. `start` is a level that is sampled only when
// leaving IDLE or HOLDOFF. All outputs are registered.

module echo_sequencer #(
  parameter int TRIG_CYC    = 500,
  parameter int TIMEOUT_CYC = 1_500_000,
  parameter int REPEAT_CYC  = 3_000_000,
  parameter int CNT_W       = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       echo,
  output logic       trig,
  output logic       enable,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    WAIT_HI = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_CYC - 1);

  state_t           state_q;
  logic             trig_q, enable_q, busy_q, timeout_q;
  logic [CNT_W-1:0] cnt_q;     // per-state counter: trig width / timeouts
  logic [CNT_W-1:0] period_q;  // cycles since the last trig rise
  logic [CNT_W-1:0] cnt_inc_d, period_inc_d;
  logic             sync1_q, sync2_q;
  logic             echo_s;

  // ---------------------------------------------------------------------
  // Echo synchronizer (and optional stability filter)
  // ---------------------------------------------------------------------
`ifdef ECHO_GLITCH_FILTER_EN
  logic sync3_q, filt_q;

  // The filter output follows only once three consecutive synchronized
  // samples agree. A pulse or gap shorter than 3 cycles therefore never
  // fills all three stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (sync1_q && sync2_q && sync3_q)
        filt_q <= 1'b1;
      else if (!sync1_q && !sync2_q && !sync3_q)
        filt_q <= 1'b0;
    end
  end

  assign echo_s = filt_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

  assign echo_s = sync2_q;
`endif

  // Saturating increments: the counters hold at all-ones and never wrap.
  assign cnt_inc_d    = (cnt_q == CNT_MAX)    ? cnt_q    : cnt_q + CNT_ONE;
  assign period_inc_d = (period_q == CNT_MAX) ? period_q : period_q + CNT_ONE;

  // ---------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      cnt_q     <= cnt_inc_d;
      period_q  <= period_inc_d;
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          period_q <= '0;
          if (start) begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            state_q <= WAIT_HI;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        WAIT_HI: begin
          // When an echo and the timeout land in the same cycle, the echo wins.
          if (echo_s) begin
            state_q  <= ECHO;
            enable_q <= 1'b1;
            cnt_q    <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= HOLDOFF;
            timeout_q <= 1'b1;
          end
        end
        ECHO: begin
          if (!echo_s) begin
            state_q  <= HOLDOFF;
            enable_q <= 1'b0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= HOLDOFF;
            enable_q  <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        HOLDOFF: begin
          // A still-high echo extends HOLDOFF with no bound. This stops the
          // next trigger from firing into a live echo.
          if (period_q >= REPEAT_LAST && !echo_s) begin
            cnt_q    <= '0;
            period_q <= '0;
            if (start) begin
              state_q <= TRIG;
              trig_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          trig_q   <= 1'b0;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign trig    = trig_q;
  assign enable  = enable_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_echo_sequencer.sv
// Directed testbench for echo_sequencer with TRIG_CYC=4, TIMEOUT_CYC=50 and
// REPEAT_CYC=120. Each scenario drives per-cycle stimulus, records the
// outputs after every clock edge into history arrays, and checks edge
// indices and pulse widths against hand-computed values.
// Index i in the history is the output after edge i. Inputs for edge i are
// applied just before that edge.

module tb_echo_sequencer;

  localparam int TRIG_CYC    = 4;
  localparam int TIMEOUT_CYC = 50;
  localparam int REPEAT_CYC  = 120;
  localparam int HMAX        = 256;

`ifdef ECHO_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       clk, rst, start, echo;
  logic       trig, enable, busy, timeout;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic       tr_h [0:HMAX-1];
  logic       en_h [0:HMAX-1];
  logic       to_h [0:HMAX-1];
  logic       bz_h [0:HMAX-1];
  logic [2:0] st_h [0:HMAX-1];

  echo_sequencer #(
    .TRIG_CYC   (TRIG_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .REPEAT_CYC (REPEAT_CYC),
    .CNT_W      (22)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .echo   (echo),
    .trig   (trig),
    .enable (enable),
    .busy   (busy),
    .timeout(timeout),
    .state_o(state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; echo = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Drivers. start is high for steps < start_stop, echo is high for steps
  // in [rise, fall), and rst is high only at step rst_at.
  task automatic run(input int n, input int start_stop, input int rise,
                     input int fall, input int rst_at);
    for (int i = 0; i < n; i++) begin
      start = (i < start_stop);
      echo  = (i >= rise && i < fall);
      rst   = (i == rst_at);
      tick();
      tr_h[i] = trig; en_h[i] = enable; to_h[i] = timeout;
      bz_h[i] = busy; st_h[i] = state_o;
    end
    rst = 1'b0;
  endtask

  function automatic logic hv(input int sel, input int i);
    case (sel)
      0: return tr_h[i];
      1: return en_h[i];
      2: return to_h[i];
      default: return bz_h[i];
    endcase
  endfunction

  function automatic int first_high(input int sel, input int from, input int to);
    for (int i = from; i < to; i++) if (hv(sel, i) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_high(input int sel, input int from, input int to);
    int c = 0;
    for (int i = from; i < to; i++) if (hv(sel, i) === 1'b1) c++;
    return c;
  endfunction

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; echo = 1'b1;
    repeat (2) tick();
    n_checks++; if (trig !== 1'b0) begin n_errors++; $display("FAIL reset_trig: got %b expected 0", trig); end
    n_checks++; if (enable !== 1'b0) begin n_errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    n_checks++; if (state_o !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    rst = 1'b0; start = 1'b0; echo = 1'b0;
  endtask

  task automatic test_normal();
    int got;
    do_reset();
    run(130, 1000, 15, 35, -1);
    got = first_high(0, 0, 130);
    n_checks++; if (got !== 0) begin n_errors++; $display("FAIL normal_trig_rise: got %0d expected 0", got); end
    got = count_high(0, 0, 10);
    n_checks++; if (got !== 4) begin n_errors++; $display("FAIL normal_trig_width: got %0d expected 4", got); end
    n_checks++; if (bz_h[0] !== 1'b1) begin n_errors++; $display("FAIL normal_busy_rise: got %b expected 1", bz_h[0]); end
    got = first_high(1, 0, 130);
    n_checks++; if (got !== 15 + LAT - 1) begin n_errors++; $display("FAIL normal_enable_rise: got %0d expected %0d", got, 15 + LAT - 1); end
    got = count_high(1, 0, 130);
    n_checks++; if (got !== 20) begin n_errors++; $display("FAIL normal_enable_width: got %0d expected 20", got); end
    got = count_high(2, 0, 130);
    n_checks++; if (got !== 0) begin n_errors++; $display("FAIL normal_timeout_count: got %0d expected 0", got); end
    got = first_high(0, 5, 130);
    n_checks++; if (got !== 120) begin n_errors++; $display("FAIL normal_next_trig: got %0d expected 120", got); end
  endtask

  task automatic test_no_echo();
    int got;
    do_reset();
    run(130, 1000, -1, -1, -1);
    got = first_high(2, 0, 130);
    n_checks++; if (got !== 54) begin n_errors++; $display("FAIL noecho_timeout_edge: got %0d expected 54", got); end
    got = count_high(2, 0, 120);
    n_checks++; if (got !== 1) begin n_errors++; $display("FAIL noecho_timeout_count: got %0d expected 1", got); end
    got = count_high(1, 0, 130);
    n_checks++; if (got !== 0) begin n_errors++; $display("FAIL noecho_enable: got %0d expected 0", got); end
    got = first_high(0, 5, 130);
    n_checks++; if (got !== 120) begin n_errors++; $display("FAIL noecho_next_trig: got %0d expected 120", got); end
  endtask

  task automatic test_stuck_echo();
    int got;
    do_reset();
    run(230, 1000, 15, 215, -1);
    got = count_high(1, 0, 230);
    n_checks++; if (got !== 50) begin n_errors++; $display("FAIL stuck_enable_width: got %0d expected 50", got); end
    got = first_high(2, 0, 230);
    n_checks++; if (got !== 15 + LAT - 1 + 50) begin n_errors++; $display("FAIL stuck_timeout_edge: got %0d expected %0d", got, 15 + LAT - 1 + 50); end
    got = count_high(2, 0, 230);
    n_checks++; if (got !== 1) begin n_errors++; $display("FAIL stuck_timeout_count: got %0d expected 1", got); end
    got = first_high(0, 5, 230);
    n_checks++; if (got !== 215 + LAT - 1) begin n_errors++; $display("FAIL stuck_next_trig: got %0d expected %0d", got, 215 + LAT - 1); end
  endtask

  task automatic test_reset_in_echo();
    int e0;
    e0 = 15 + LAT - 1;
    do_reset();
    run(e0 + 10, 1000, 15, 35, e0 + 5);
    n_checks++; if (en_h[e0 + 4] !== 1'b1) begin n_errors++; $display("FAIL rstecho_window_open: got %b expected 1", en_h[e0 + 4]); end
    n_checks++; if (en_h[e0 + 5] !== 1'b0) begin n_errors++; $display("FAIL rstecho_enable: got %b expected 0", en_h[e0 + 5]); end
    n_checks++; if (bz_h[e0 + 5] !== 1'b0) begin n_errors++; $display("FAIL rstecho_busy: got %b expected 0", bz_h[e0 + 5]); end
    n_checks++; if ({tr_h[e0 + 5], to_h[e0 + 5]} !== 2'b00) begin n_errors++; $display("FAIL rstecho_trig_timeout: got %b%b expected 00", tr_h[e0 + 5], to_h[e0 + 5]); end
    n_checks++; if (st_h[e0 + 5] !== 3'd0) begin n_errors++; $display("FAIL rstecho_state: got %0d expected 0", st_h[e0 + 5]); end
    n_checks++; if (tr_h[e0 + 6] !== 1'b1) begin n_errors++; $display("FAIL rstecho_retrig: got %b expected 1", tr_h[e0 + 6]); end
  endtask

  task automatic test_start_release();
    int got;
    do_reset();
    run(160, 10, 15, 35, -1);
    got = count_high(1, 0, 160);
    n_checks++; if (got !== 20) begin n_errors++; $display("FAIL release_enable_width: got %0d expected 20", got); end
    n_checks++; if (bz_h[119] !== 1'b1) begin n_errors++; $display("FAIL release_busy_held: got %b expected 1", bz_h[119]); end
    n_checks++; if (bz_h[120] !== 1'b0) begin n_errors++; $display("FAIL release_busy_fall: got %b expected 0", bz_h[120]); end
    got = count_high(0, 5, 160);
    n_checks++; if (got !== 0) begin n_errors++; $display("FAIL release_no_trig: got %0d expected 0", got); end
  endtask

  // A 2-cycle pulse, then a 20-cycle pulse. With the filter the short one is
  // dropped. Without it the short pulse becomes the measurement.
  task automatic test_glitch();
    int got, exp_rise, exp_w;
`ifdef ECHO_GLITCH_FILTER_EN
    exp_rise = 30 + LAT - 1; exp_w = 20;
`else
    exp_rise = 15 + LAT - 1; exp_w = 2;
`endif
    do_reset();
    for (int i = 0; i < 60; i++) begin
      start = 1'b1;
      echo  = (i >= 15 && i < 17) || (i >= 30 && i < 50);
      tick();
      en_h[i] = enable;
    end
    got = first_high(1, 0, 60);
    n_checks++; if (got !== exp_rise) begin n_errors++; $display("FAIL glitch_enable_rise: got %0d expected %0d", got, exp_rise); end
    got = count_high(1, 0, 60);
    n_checks++; if (got !== exp_w) begin n_errors++; $display("FAIL glitch_enable_width: got %0d expected %0d", got, exp_w); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; echo = 1'b0;
    test_reset();
    test_normal();
    test_no_echo();
    test_stuck_echo();
    test_reset_in_echo();
    test_start_release();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/echo_sequencer.md
# echo_sequencer

Drives one ultrasonic ranging cycle and produces the clean `enable` window consumed by the downstream pulse-period counter. It has these jobs:
- emit the trigger pulse;
- synchronize the asynchronous echo input;
- gate the echo into `enable`, with timeouts;
- repeat at a fixed rate while `start` is held.

It sits between the sensor pins and the period counter that feeds the pet's proximity logic.

## Interface
Clock `clk`, reset `rst`: one clock; reset is synchronous and active-high.

Parameters:
- TRIG_CYC, 500: trigger pulse width in clk cycles (10 µs at 50 MHz).
- TIMEOUT_CYC, 1_500_000: maximum wait for echo rise, and maximum echo-high width.
- REPEAT_CYC, 3_000_000: trig-rise to trig-rise period. Must be ≥ TRIG_CYC + 2·TIMEOUT_CYC + 4.
- CNT_W, 22: width of internal counters. Must hold REPEAT_CYC.

Ports:
- clk: input, 1, system clock.
- rst: input, 1, synchronous active-high reset.
- start: input, 1, level. While 1, measurements repeat; sampled only in IDLE/HOLDOFF exit.
- echo: input, 1, asynchronous sensor echo.
- trig: output, 1, sensor trigger pulse.
- enable: output, 1, measurement window to the period counter.
- busy: output, 1, high whenever state ≠ IDLE.
- timeout: output, 1, one-cycle pulse on either timeout.

## Operation
- Echo synchronizer:
  - 2-FF chain gives `echo_s`.
  - `echo_s` is the only echo signal the FSM uses.
- FSM states: IDLE, TRIG, WAIT_HI, ECHO, HOLDOFF.
- IDLE:
  - trig=0, enable=0, counters cleared.
  - start=1 → TRIG.
- TRIG:
  - trig=1 for exactly TRIG_CYC cycles, then → WAIT_HI.
  - Period counter starts at 0 on TRIG entry.
- WAIT_HI:
  - Timeout counter starts at 0 on entry.
  - echo_s=1 → ECHO.
  - TIMEOUT_CYC cycles elapsed with echo_s=0 → timeout pulse, go to HOLDOFF.
  - If both are true in the same cycle, echo wins.
- ECHO:
  - enable=1.
  - echo_s=0 → enable=0, go to HOLDOFF.
  - enable high for TIMEOUT_CYC cycles → force enable=0, timeout pulse, go to HOLDOFF.
- HOLDOFF:
  - enable=0, trig=0.
  - Exit when the period counter reaches REPEAT_CYC−1 and echo_s=0.
  - If echo_s is still high, stay in HOLDOFF until it falls, with no timeout.
  - On exit: start=1 → TRIG, else → IDLE.
- Counters saturate at all-ones; they never wrap.
- Reset mid-operation: every output is 0 on the next edge and the state is IDLE. A reset during ECHO therefore drops `enable`; the downstream counter sees a normal window end, and the consumer discards that result because `busy` also fell.
- `start` dropping mid-measurement does not abort. The current cycle completes, then the FSM goes to IDLE.

## Timing
- Reset values: trig=0, enable=0, busy=0, timeout=0, synchronizer flops 0, state IDLE.
- All outputs are registered.
- start=1 in IDLE at edge N → trig=1 from edge N+1 through N+TRIG_CYC; trig=0 at N+TRIG_CYC+1.
- Echo latency:
  - Pin rise to enable rise: 3 cycles (2 synchronizer + 1 FSM).
  - Pin fall to enable fall: also 3 cycles.
  - Hence enable width equals the echo high width in cycles (±1 sampling).
- timeout is asserted on the same edge the state becomes HOLDOFF, for 1 cycle.
- With start held and normal echoes, consecutive trig rising edges are exactly REPEAT_CYC cycles apart.
- busy rises with trig and falls on the edge entering IDLE.

## Configuration
- Macro ECHO_GLITCH_FILTER_EN.
- Defined:
  - A stability filter follows the synchronizer. echo_s changes only after the synchronized value has held for 3 consecutive cycles.
  - Pulses or gaps shorter than 3 cycles are ignored.
  - Latency becomes 5 cycles on both edges, so width is preserved.
- Undefined:
  - Plain 2-FF synchronizer, 3-cycle latency.
  - Every sampled transition is honored.

## Test plan
Bench parameters for all scenarios: TRIG_CYC=4, TIMEOUT_CYC=50, REPEAT_CYC=120.
- Normal: start=1; echo rises 10 cycles after trig falls and stays high 20 cycles → trig high 4 cycles; enable high exactly 20 cycles, starting 3 cycles after echo rise; timeout never pulses; next trig rise 120 cycles after the first.
- No echo: start=1, echo held 0 → timeout pulses once exactly 50 cycles after WAIT_HI entry; enable stays 0; next trig at 120.
- Stuck echo: echo rises and stays high 200 cycles → enable high exactly 50 cycles; timeout pulses; no new trig until 3 cycles after echo falls.
- Reset in ECHO: rst=1 for 1 cycle, 5 cycles into the enable window → next edge all outputs 0, state IDLE; with start=1, trig rises on the edge after rst releases.
- Start released: start drops during WAIT_HI; echo normal → measurement completes; busy falls at REPEAT_CYC; no further trig.
- Glitch (ECHO_GLITCH_FILTER_EN defined): 2-cycle echo pulse, then a 20-cycle pulse → first pulse ignored; enable high 20 cycles, starting 5 cycles after the second rise.
